uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver: the receive end of the link driven by the team's UART transmitter (8 data bits, LSB first, 1 start bit, 1 stop bit, idle high, optional parity). It synchronises the asynchronous line, detects and validates the start bit, and samples every bit at its centre. It delivers each byte with a single-cycle `data_valid` pulse, or raises an error pulse instead. It sits beside the transmitter in the UART top level and shares its `CLKS_PER_BIT` setting.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per serial bit; must be ≥ 4. The default gives 9600 baud from 50 MHz.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `rx_in`  input  1  serial line, asynchronous to `clk`, idles high.
- `par_typ`  input  1  parity type: 0 = even, 1 = odd. It is used only when `UART_RX_PARITY_EN` is defined. Hold it stable while `busy` is high.
- `p_data`  output  8  last correctly received byte; held until the next good frame.
- `data_valid`  output  1  one-cycle pulse; `p_data` is valid in the same cycle.
- `busy`  output  1  high from start detection until the frame ends or is aborted.
- `framing_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `par_err`  output  1  one-cycle pulse when the parity check fails; constant 0 without the macro.

## Operation
- **Input synchroniser:** two flip-flops on `rx_in`; both reset to 1. All decisions use the synchronised value `rx_s`.
- **Counters:**
  - Bit-period counter: width `$clog2(CLKS_PER_BIT)`; it is cleared on every state entry and on every sample.
  - Bit index: 3 bits, counting 0..7.
  - Data bits shift into an 8-bit register, LSB first.
- **States and transitions:**
  - IDLE: when `rx_s`=0, go to START, set `busy`=1 and clear the counter. Detection cycle = D.
  - START: at count `CLKS_PER_BIT/2-1` (integer division), re-sample `rx_s`.
    - If it is 0, go to DATA.
    - If it is 1, treat it as a glitch: go to IDLE, `busy`=0, no pulses.
  - DATA: sample one bit every `CLKS_PER_BIT` cycles. After bit 7, go to PARITY if the macro is defined, otherwise go to STOP.
  - PARITY: sample the parity bit after `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles, then go to DONE.
  - DONE: one cycle that produces the result, then go to IDLE with `busy`=0.
- **Result produced in DONE (exactly one of the following):**
  - If stop = 1 and parity is OK: `p_data` ← shift register and `data_valid`=1.
  - If stop = 0: `framing_err`=1. This takes priority over `par_err`.
  - If stop = 1 and parity fails: `par_err`=1.
  - On either error, `p_data` is unchanged and `data_valid` stays 0.
- **Next frame:** IDLE may detect a new start bit in the cycle immediately after DONE. The remaining half stop bit is high, so it cannot cause a false start.
- **Line stuck low:** after a framing error with the line still low, IDLE re-detects a start bit immediately. This is the required behaviour (break condition → repeated `framing_err`).
- **Reset mid-frame:** reset asserted mid-frame aborts the frame with no pulses. After release, the receiver waits in IDLE for the next falling edge.

## Timing
- **Reset values:** `p_data`=8'h00, `data_valid`=0, `busy`=0, `framing_err`=0, `par_err`=0. The FSM is in IDLE and the synchroniser is at 1.
- **Input delay:** D is 2–3 clocks after the falling edge on `rx_in`, because of the synchroniser.
- **Sample points (H = `CLKS_PER_BIT/2`, N = `CLKS_PER_BIT`):**
  - Start check: D+H.
  - Data bit i: D+H+(i+1)·N.
  - Parity bit: D+H+9·N.
  - Stop bit: D+H+9·N without parity, or D+H+10·N with parity.
- **Result timing:** the result pulse comes one cycle after the stop sample. `busy` falls in that same cycle.
- **Pulse widths:** `data_valid`, `framing_err` and `par_err` are each exactly one cycle wide and are never asserted together.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 11 bits and the PARITY state is compiled in.
  - Parity check: XOR of the 8 data bits and the received parity bit must equal `par_typ`. A mismatch raises `par_err`.
- Undefined:
  - The frame is 10 bits and the PARITY state is absent.
  - `par_typ` is ignored and `par_err` is tied to 0.

## Test plan
All tests use `CLKS_PER_BIT`=16.
- **Good frame:** send 0xA5 as a clean frame → `data_valid` pulses once at D+8+9·16+1 (no parity), `p_data`=0xA5, `busy` is high for the whole frame, no error pulses.
- **Glitch rejection:** a low pulse of 4 clocks on an idle line → `busy` rises then falls at D+8, no pulses, `p_data` unchanged.
- **Framing error:** send 0x3C with stop bit = 0, after a good 0x11 → exactly one `framing_err` pulse, `data_valid`=0, `p_data` stays 0x11.
- **Back-to-back frames:** 0x00 then 0xFF with no idle gap → two `data_valid` pulses, `p_data`=0x00 then 0xFF.
- **Reset mid-frame:** drop `rst` at bit 4 of 0x5A → outputs go to their reset values immediately. A following 0xC3 frame is received correctly.
- **With `UART_RX_PARITY_EN`:**
  - `par_typ`=0, 0x07 with parity bit 1 → `data_valid`.
  - Same frame with parity bit 0 → `par_err` only, `p_data` unchanged.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 start, 1 stop, idle high, centre sampled.
// Define UART_RX_PARITY_EN to add a parity bit (checked against par_typ) before the stop bit.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_typ,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       busy,
  output logic       framing_err,
  output logic       par_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  logic             rx_meta, rx_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_q, stop_d;
  logic [7:0]       p_data_d;
  logic             busy_d, dv_d, fe_d;

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic pe_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q   <= 1'b0;
      par_err <= 1'b0;
    end else begin
      par_q   <= par_d;
      par_err <= pe_d;
    end
  end
`else
  logic unused_par_typ;
  assign unused_par_typ = par_typ;
  assign par_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      stop_q      <= 1'b1;
      p_data      <= '0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      stop_q      <= stop_d;
      p_data      <= p_data_d;
      busy        <= busy_d;
      data_valid  <= dv_d;
      framing_err <= fe_d;
    end
  end

  // Next state, counters and registered-output next values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    stop_d   = stop_q;
    p_data_d = p_data;
    busy_d   = busy;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    pe_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          stop_d  = rx_s;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        busy_d  = 1'b0;
        // Framing error outranks parity error; p_data only moves on a good frame
        if (!stop_q) begin
          fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if ((^shift_q ^ par_q) != par_typ) begin
          pe_d = 1'b1;
`endif
        end else begin
          dv_d     = 1'b1;
          p_data_d = shift_q;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a frame-level model.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int F = 10;
`else
  localparam int F = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, busy, framing_err, par_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, overlap_cnt = 0;
  int dv_cyc = -1, fe_cyc = -1, rise_cyc = -1, fall_cyc = -1;
  logic busy_prev = 1'b0;
  logic [7:0] exp_pdata = 8'h00;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_typ(par_typ),
    .p_data(p_data), .data_valid(data_valid), .busy(busy),
    .framing_err(framing_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  // Event monitor: samples just after each rising edge; cyc numbers the edges
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (data_valid === 1'b1) begin dv_cnt = dv_cnt + 1; dv_cyc = cyc; end
    if (framing_err === 1'b1) begin fe_cnt = fe_cnt + 1; fe_cyc = cyc; end
    if (par_err === 1'b1) pe_cnt = pe_cnt + 1;
    if (int'(data_valid) + int'(framing_err) + int'(par_err) > 1) overlap_cnt = overlap_cnt + 1;
    if (busy === 1'b1 && busy_prev === 1'b0) rise_cyc = cyc;
    if (busy === 1'b0 && busy_prev === 1'b1) fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: 0 = good byte, 1 = framing error, 2 = parity error
  function automatic int model_kind(logic [7:0] b, logic stop_bit, logic par_bit, logic ptyp);
    int  ones;
    logic par_ok;
    ones   = $countones(b) + int'(par_bit);
    par_ok = ((ones % 2) == int'(ptyp));
`ifndef UART_RX_PARITY_EN
    par_ok = 1'b1;
`endif
    if (!stop_bit) return 1;
    if (!par_ok) return 2;
    return 0;
  endfunction

  // Send one frame from a negedge, then idle for gap cycles, and check the outcome
  task automatic do_frame(input string tag, input logic [7:0] b, input logic stop_bit,
                          input logic par_bit, input int gap);
    int start, kind, dv0, fe0, pe0, exp_res;
    logic bits[$];
    kind  = model_kind(b, stop_bit, par_bit, par_typ);
    dv0   = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    start = cyc;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back(par_bit);
`endif
    bits.push_back(stop_bit);
    foreach (bits[i]) begin
      rx_in = bits[i];
      repeat (N) @(negedge clk);
    end
    rx_in = 1'b1;
    // Line level reaches the FSM three edges after it is driven; result one edge after stop centre
    exp_res = start + 3 + H + F * N + 1;
    chk({tag, "_dv"}, 32'(dv_cnt - dv0), 32'(kind == 0));
    chk({tag, "_fe"}, 32'(fe_cnt - fe0), 32'(kind == 1));
    chk({tag, "_pe"}, 32'(pe_cnt - pe0), 32'(kind == 2));
    if (kind == 0) begin
      exp_pdata = b;
      chk({tag, "_dv_time"}, 32'(dv_cyc), 32'(exp_res));
      chk({tag, "_busy_rise"}, 32'(rise_cyc), 32'(start + 3));
      chk({tag, "_busy_fall"}, 32'(fall_cyc), 32'(exp_res));
    end else if (kind == 1) begin
      chk({tag, "_fe_time"}, 32'(fe_cyc), 32'(exp_res));
    end
    chk({tag, "_pdata"}, 32'(p_data), 32'(exp_pdata));
    chk({tag, "_overlap"}, 32'(overlap_cnt), 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int start, dv0, fe0, pe0, rel;
    logic [7:0] v, rb;
    logic rs, rp;

    repeat (3) @(negedge clk);
    chk("rst_pdata", 32'(p_data), 32'h00);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fe", 32'(framing_err), 32'd0);
    chk("rst_pe", 32'(par_err), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    do_frame("good_a5", 8'hA5, 1'b1, ^8'hA5, 2 * N);

    // Short low glitch on an idle line
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    start = cyc;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * N) @(negedge clk);
    chk("glitch_rise", 32'(rise_cyc), 32'(start + 3));
    chk("glitch_fall", 32'(fall_cyc), 32'(start + 3 + H));
    chk("glitch_pulses", 32'((dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
    chk("glitch_pdata", 32'(p_data), 32'(exp_pdata));

    do_frame("good_11", 8'h11, 1'b1, ^8'h11, N);
    do_frame("ferr_3c", 8'h3C, 1'b0, ^8'h3C, 2 * N);

    do_frame("b2b_00", 8'h00, 1'b1, 1'b0, 0);
    do_frame("b2b_ff", 8'hFF, 1'b1, 1'b0, 2 * N);

    // Line held low: a break yields back-to-back framing errors
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    rel = 2 * (H + F * N + 2) + 4;
    rx_in = 1'b0;
    repeat (rel) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * N) @(negedge clk);
    chk("break_fe", 32'(fe_cnt - fe0), 32'd2);
    chk("break_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("break_pe", 32'(pe_cnt - pe0), 32'd0);
    chk("break_pdata", 32'(p_data), 32'(exp_pdata));
    chk("break_busy", 32'(busy), 32'd0);

    // Reset dropped at data bit 4 of 0x5A
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    v = 8'h5A;
    rx_in = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = v[i];
      repeat (N) @(negedge clk);
    end
    rx_in = v[4];
    repeat (H) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_pdata = 8'h00;
    chk("midrst_pdata", 32'(p_data), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dv", 32'(data_valid), 32'd0);
    chk("midrst_fe", 32'(framing_err), 32'd0);
    chk("midrst_pe", 32'(par_err), 32'd0);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2 * N) @(negedge clk);
    chk("midrst_pulses", 32'((dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
    do_frame("after_rst_c3", 8'hC3, 1'b1, ^8'hC3, 2 * N);

`ifdef UART_RX_PARITY_EN
    par_typ = 1'b0;
    do_frame("par_ok_07", 8'h07, 1'b1, 1'b1, 2 * N);
    do_frame("par_bad_07", 8'h07, 1'b1, 1'b0, 2 * N);
`endif

    // Randomized frames; an errored stop bit is followed by an idle gap
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom_range(0, 1));
`ifdef UART_RX_PARITY_EN
      par_typ = 1'($urandom_range(0, 1));
`endif
      do_frame($sformatf("rand%0d", k), rb, rs, rp, rs ? int'($urandom_range(0, 1)) * N : 2 * N);
    end
    repeat (2 * N) @(negedge clk);
    chk("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
